conv_first_to_last_with_ready: RTL and testbench

Converts an upstream stream marked with 'first' into a downstream stream marked with 'last', with full valid/ready backpressure on both sides. This is the inverse direction of the existing last-to-first converter. A beat cannot be known to be last until the next beat (or a flush) arrives, so the block holds one beat in a skid/holding register. It sits between packet producers that mark packet starts and consumers (serialisers, FIFO writers) that need packet ends. It also reports the beat index within the packet and flags protocol errors.

---
 rtl/conv_pkg.sv | 20 ++
 rtl/conv_first_to_last_with_ready_if.sv | 27 ++
 rtl/stream_hold_reg.sv | 41 ++++
 rtl/conv_first_to_last_with_ready.sv | 85 ++++++++
 tb/tb_conv_first_to_last_with_ready.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/conv_pkg.sv
// Shared definitions for the stream marker converters (first<->last).
package conv_pkg;

   localparam int unsigned DEF_WIDTH   = 8;
   localparam int unsigned DEF_MAX_LEN = 256;

   function automatic int unsigned index_w(input int unsigned max_len);
      return $clog2(max_len);
   endfunction

   localparam int unsigned DEF_IDX_W = index_w(DEF_MAX_LEN);

   // One beat as seen on a converter port; marker is first or last depending on side.
   typedef struct packed {
      logic [DEF_WIDTH-1:0] data;
      logic                 marker;
      logic [DEF_IDX_W-1:0] index;
   } stream_beat_t;

endpackage

// File: rtl/conv_first_to_last_with_ready_if.sv
// Upstream (first-marked) and downstream (last-marked) handshake bundle.
interface conv_first_to_last_with_ready_if #(
   parameter int unsigned width = 8,
   parameter int unsigned idx_w = 8
);
   logic             up_valid;
   logic             up_ready;
   logic             up_first;
   logic [width-1:0] up_data;
   logic             flush;
   logic             down_valid;
   logic             down_ready;
   logic             down_last;
   logic [width-1:0] down_data;
   logic [idx_w-1:0] down_index;
   logic             proto_err;

   modport master (
      output up_valid, up_first, up_data, flush, down_ready,
      input  up_ready, down_valid, down_last, down_data, down_index, proto_err
   );

   modport slave (
      input  up_valid, up_first, up_data, flush, down_ready,
      output up_ready, down_valid, down_last, down_data, down_index, proto_err
   );
endinterface

// File: rtl/stream_hold_reg.sv
// One-entry holding register with load/unload handshake; load wins over unload.
module stream_hold_reg #(
   parameter int unsigned width = 8
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             load,
   input  logic             unload,
   input  logic [width-1:0] load_data,
   output logic             load_ready_c,
   output logic             held_valid,
   output logic [width-1:0] held_data
);
   logic             valid_q, valid_d;
   logic [width-1:0] data_q, data_d;

   always_ff @(posedge clock) begin
      if (reset) begin
         valid_q <= 1'b0;
         data_q  <= '0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
      end
   end

   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      if (load) begin
         valid_d = 1'b1;
         data_d  = load_data;
      end else if (unload) begin
         valid_d = 1'b0;
      end
   end

   assign load_ready_c = ~valid_q | unload;
   assign held_valid   = valid_q;
   assign held_data    = data_q;
endmodule

// File: rtl/conv_first_to_last_with_ready.sv
// Converts a first-marked stream to a last-marked one by holding one beat until
// its successor (or a flush) shows whether it ends the packet.
module conv_first_to_last_with_ready
   import conv_pkg::*;
#(
   parameter int unsigned width   = DEF_WIDTH,
   parameter int unsigned max_len = DEF_MAX_LEN
) (
   input logic clock,
   input logic reset,
   conv_first_to_last_with_ready_if.slave bus
);
   localparam int unsigned idx_w  = index_w(max_len);
   localparam int unsigned hold_w = width + idx_w;
   localparam logic [idx_w-1:0] idx_max = idx_w'(max_len - 1);

   logic              held_valid;
   logic              load_ready_c;
   logic [hold_w-1:0] held_word;
   logic [hold_w-1:0] load_word;
   logic [width-1:0]  held_data;
   logic [idx_w-1:0]  held_index;
   logic [idx_w-1:0]  next_index;
   logic              down_valid_c;
   logic              down_last_c;
   logic              down_fire;
   logic              up_fire;
   logic              zero_index;
   logic              saturated;
   logic              expect_first_q, expect_first_d;
   logic              proto_err_q, proto_err_d;

   // Index travels with the data so the held beat carries its own position.
   stream_hold_reg #(.width(hold_w)) u_hold (
      .clock        (clock),
      .reset        (reset),
      .load         (up_fire),
      .unload       (down_fire),
      .load_data    (load_word),
      .load_ready_c (load_ready_c),
      .held_valid   (held_valid),
      .held_data    (held_word)
   );

   assign {held_index, held_data} = held_word;

   always_ff @(posedge clock) begin
      if (reset) begin
         expect_first_q <= 1'b1;
         proto_err_q    <= 1'b0;
      end else begin
         expect_first_q <= expect_first_d;
         proto_err_q    <= proto_err_d;
      end
   end

   always_comb begin
      down_valid_c = held_valid & (bus.up_valid | bus.flush);
      down_last_c  = down_valid_c & (bus.flush | (bus.up_valid & bus.up_first));
      down_fire    = down_valid_c & bus.down_ready;
      up_fire      = bus.up_valid & load_ready_c;
      // A flushed predecessor closes its packet, so the incoming beat restarts at 0.
      zero_index   = bus.up_first | expect_first_q | (down_fire & bus.flush);
      saturated    = (held_index == idx_max);
      next_index   = '0;
      if (!zero_index) begin
         next_index = saturated ? held_index : held_index + idx_w'(1);
      end
      load_word      = {next_index, bus.up_data};
      expect_first_d = expect_first_q;
      if (up_fire) begin
         expect_first_d = 1'b0;
      end else if (down_fire & down_last_c) begin
         expect_first_d = 1'b1;
      end
      proto_err_d = up_fire & ((expect_first_q & ~bus.up_first) | (~zero_index & saturated));
   end

   assign bus.up_ready   = load_ready_c;
   assign bus.down_valid = down_valid_c;
   assign bus.down_last  = down_last_c;
   assign bus.down_data  = held_data;
   assign bus.down_index = held_index;
   assign bus.proto_err  = proto_err_q;
endmodule

// File: tb/tb_conv_first_to_last_with_ready.sv
// Scoreboard bench: directed packets with hand-computed downstream beats, one DUT at
// max_len=256 and one at max_len=4 for index saturation.
module tb_conv_first_to_last_with_ready;
   import conv_pkg::*;

   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;

   conv_first_to_last_with_ready_if #(.width(8), .idx_w(8)) bus_a ();
   conv_first_to_last_with_ready_if #(.width(8), .idx_w(2)) bus_b ();

   conv_first_to_last_with_ready #(.width(8), .max_len(256)) dut_a (
      .clock (clock), .reset (reset), .bus (bus_a.slave));
   conv_first_to_last_with_ready #(.width(8), .max_len(4)) dut_b (
      .clock (clock), .reset (reset), .bus (bus_b.slave));

   int           n_checks = 0;
   int           n_fail   = 0;
   int           err_a    = 0;
   int           err_b    = 0;
   bit           rand_ready = 1'b0;
   bit           stall_prev = 1'b0;
   stream_beat_t stall_beat;
   stream_beat_t exp_a[$];
   stream_beat_t exp_b[$];
   stream_beat_t pop_a, pop_b, seen_a, seen_b;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: actual %0h required %0h at %0t", name, act, req, $time);
      end
   endtask

   function automatic stream_beat_t bt(input logic [7:0] d, input logic l, input logic [7:0] i);
      stream_beat_t b;
      b.data = d; b.marker = l; b.index = i;
      return b;
   endfunction

   // Downstream randomisation for dut_a only.
   always @(posedge clock) begin
      #1;
      bus_a.down_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
   end

   // Monitor A: pops on every downstream transfer, checks stability under backpressure.
   always @(negedge clock) begin
      if (reset) begin
         stall_prev = 1'b0;
      end else begin
         seen_a = bt(bus_a.down_data, bus_a.down_last, bus_a.down_index);
         if (stall_prev) begin
            check("a_stall_valid", 32'(bus_a.down_valid), 32'(1));
            check("a_stall_beat", 32'(seen_a), 32'(stall_beat));
         end
         if (bus_a.down_valid && bus_a.down_ready) begin
            if (exp_a.size() == 0) begin
               n_checks++; n_fail++;
               $display("FAIL a_extra_beat: actual %0h required none", 32'(seen_a));
            end else begin
               pop_a = exp_a.pop_front();
               check("a_beat", 32'(seen_a), 32'(pop_a));
            end
         end
         stall_prev = bus_a.down_valid && !bus_a.down_ready;
         stall_beat = seen_a;
         if (bus_a.proto_err) err_a++;
      end
   end

   // Monitor B.
   always @(negedge clock) begin
      if (!reset) begin
         seen_b = bt(bus_b.down_data, bus_b.down_last, 8'(bus_b.down_index));
         if (bus_b.down_valid && bus_b.down_ready) begin
            if (exp_b.size() == 0) begin
               n_checks++; n_fail++;
               $display("FAIL b_extra_beat: actual %0h required none", 32'(seen_b));
            end else begin
               pop_b = exp_b.pop_front();
               check("b_beat", 32'(seen_b), 32'(pop_b));
            end
         end
         if (bus_b.proto_err) err_b++;
      end
   end

   task automatic send(input bit which, input logic first, input logic [7:0] data);
      bit done = 1'b0;
      if (which) begin
         bus_b.up_valid = 1'b1; bus_b.up_first = first; bus_b.up_data = data;
      end else begin
         bus_a.up_valid = 1'b1; bus_a.up_first = first; bus_a.up_data = data;
      end
      for (int n = 0; n < 100 && !done; n++) begin
         @(negedge clock);
         done = which ? bus_b.up_ready : bus_a.up_ready;
         @(posedge clock); #1;
      end
      if (which) begin
         bus_b.up_valid = 1'b0; bus_b.up_first = 1'b0;
      end else begin
         bus_a.up_valid = 1'b0; bus_a.up_first = 1'b0;
      end
      if (!done) begin
         n_checks++; n_fail++;
         $display("FAIL send_timeout: actual no up_ready required accept of %0h", data);
      end
   endtask

   task automatic do_flush(input bit which);
      bit done = 1'b0;
      if (which) bus_b.flush = 1'b1; else bus_a.flush = 1'b1;
      for (int n = 0; n < 100 && !done; n++) begin
         @(negedge clock);
         done = which ? (bus_b.down_valid & bus_b.down_ready) : (bus_a.down_valid & bus_a.down_ready);
         @(posedge clock); #1;
      end
      bus_a.flush = 1'b0; bus_b.flush = 1'b0;
      if (!done) begin
         n_checks++; n_fail++;
         $display("FAIL flush_timeout: actual no release required held beat out");
      end
   endtask

   task automatic drain(input string name);
      for (int n = 0; n < 60 && (exp_a.size() + exp_b.size()) != 0; n++) @(posedge clock);
      repeat (3) @(posedge clock);
      #1;
      check(name, 32'(exp_a.size() + exp_b.size()), 32'(0));
   endtask

   task automatic do_reset();
      reset = 1'b1;
      repeat (2) @(posedge clock);
      #1 reset = 1'b0;
   endtask

   int e0;

   initial begin
      #300000;
      $display("FAIL watchdog: actual timeout required $finish");
      $fatal(1);
   end

   initial begin
      bus_a.up_valid = 1'b0; bus_a.up_first = 1'b0; bus_a.up_data = '0; bus_a.flush = 1'b0;
      bus_b.up_valid = 1'b0; bus_b.up_first = 1'b0; bus_b.up_data = '0; bus_b.flush = 1'b0;
      bus_b.down_ready = 1'b1;
      repeat (3) @(posedge clock);
      #1 reset = 1'b0;

      // Reset state
      @(negedge clock);
      check("rst_down_valid", 32'(bus_a.down_valid), 32'(0));
      check("rst_down_last", 32'(bus_a.down_last), 32'(0));
      check("rst_down_index", 32'(bus_a.down_index), 32'(0));
      check("rst_proto_err", 32'(bus_a.proto_err), 32'(0));
      check("rst_up_ready", 32'(bus_a.up_ready), 32'(1));
      check("rst_b_down_valid", 32'(bus_b.down_valid), 32'(0));
      check("rst_b_up_ready", 32'(bus_b.up_ready), 32'(1));
      @(posedge clock); #1;

      // 1: A,B,C then D with first, then flush D
      exp_a.push_back(bt(8'hA0, 1'b0, 8'd0));
      exp_a.push_back(bt(8'hB0, 1'b0, 8'd1));
      exp_a.push_back(bt(8'hC0, 1'b1, 8'd2));
      exp_a.push_back(bt(8'hD0, 1'b1, 8'd0));
      e0 = err_a;
      send(0, 1'b1, 8'hA0); send(0, 1'b0, 8'hB0); send(0, 1'b0, 8'hC0); send(0, 1'b1, 8'hD0);
      do_flush(0);
      drain("t1_drain");
      check("t1_proto_err", 32'(err_a - e0), 32'(0));

      // 2: single-beat packets
      exp_a.push_back(bt(8'h11, 1'b1, 8'd0));
      exp_a.push_back(bt(8'h22, 1'b1, 8'd0));
      exp_a.push_back(bt(8'h33, 1'b1, 8'd0));
      send(0, 1'b1, 8'h11); send(0, 1'b1, 8'h22); send(0, 1'b1, 8'h33);
      do_flush(0);
      drain("t2_drain");

      // 3: random backpressure, packets of 1,3,5,2
      exp_a.push_back(bt(8'h31, 1'b1, 8'd0));
      exp_a.push_back(bt(8'h41, 1'b0, 8'd0));
      exp_a.push_back(bt(8'h42, 1'b0, 8'd1));
      exp_a.push_back(bt(8'h43, 1'b1, 8'd2));
      for (int i = 0; i < 5; i++) exp_a.push_back(bt(8'h51 + 8'(i), i == 4, 8'(i)));
      exp_a.push_back(bt(8'h61, 1'b0, 8'd0));
      exp_a.push_back(bt(8'h62, 1'b1, 8'd1));
      e0 = err_a;
      rand_ready = 1'b1;
      send(0, 1'b1, 8'h31);
      send(0, 1'b1, 8'h41); send(0, 1'b0, 8'h42); send(0, 1'b0, 8'h43);
      for (int i = 0; i < 5; i++) send(0, i == 0, 8'h51 + 8'(i));
      send(0, 1'b1, 8'h61); send(0, 1'b0, 8'h62);
      do_flush(0);
      rand_ready = 1'b0;
      drain("t3_drain");
      check("t3_proto_err", 32'(err_a - e0), 32'(0));

      // 4: first beat after reset without first
      do_reset();
      e0 = err_a;
      exp_a.push_back(bt(8'h5A, 1'b1, 8'd0));
      send(0, 1'b0, 8'h5A);
      do_flush(0);
      drain("t4_drain");
      check("t4_proto_err", 32'(err_a - e0), 32'(1));

      // 5: max_len=4, six-beat packet saturates
      e0 = err_b;
      exp_b.push_back(bt(8'hE1, 1'b0, 8'd0));
      exp_b.push_back(bt(8'hE2, 1'b0, 8'd1));
      exp_b.push_back(bt(8'hE3, 1'b0, 8'd2));
      exp_b.push_back(bt(8'hE4, 1'b0, 8'd3));
      exp_b.push_back(bt(8'hE5, 1'b0, 8'd3));
      exp_b.push_back(bt(8'hE6, 1'b1, 8'd3));
      for (int i = 0; i < 6; i++) send(1, i == 0, 8'hE1 + 8'(i));
      do_flush(1);
      drain("t5_drain");
      check("t5_proto_err", 32'(err_b - e0), 32'(2));

      // 6: reset with a beat held mid-packet
      exp_a.push_back(bt(8'h70, 1'b0, 8'd0));
      send(0, 1'b1, 8'h70); send(0, 1'b0, 8'h71);
      drain("t6_pre_drain");
      do_reset();
      bus_a.flush = 1'b1;
      @(negedge clock);
      check("t6_down_valid", 32'(bus_a.down_valid), 32'(0));
      check("t6_up_ready", 32'(bus_a.up_ready), 32'(1));
      @(posedge clock); #1 bus_a.flush = 1'b0;
      e0 = err_a;
      exp_a.push_back(bt(8'h80, 1'b0, 8'd0));
      exp_a.push_back(bt(8'h81, 1'b1, 8'd1));
      send(0, 1'b1, 8'h80); send(0, 1'b0, 8'h81);
      do_flush(0);
      drain("t6_drain");
      check("t6_proto_err", 32'(err_a - e0), 32'(0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
